// File: rtl/debug_dump_tx.sv
// rtl/debug_dump_tx.sv - register-bank dump serializer feeding a UART transmitter
// Walks NUM_WORDS words, emitting an optional header byte then every word byte-by-byte.

module debug_dump_tx #(
  parameter int         WORD_WIDTH = 32,
  parameter int         NUM_WORDS  = 32,
  parameter int         ADDR_WIDTH = 5,
  parameter int         CNT_WIDTH  = 8,
  parameter int         MSB_FIRST  = 1,
  parameter int         HEADER_EN  = 1,
  parameter logic [7:0] HEADER     = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] word_addr,
  input  logic [WORD_WIDTH-1:0] word_in,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  input  logic                  tx_done,
  output logic                  busy,
  output logic                  sent_flag,
  output logic [CNT_WIDTH-1:0]  send_counter
);

  localparam int BYTES = WORD_WIDTH / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0]      LAST_BYTE = IDX_W'(BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE, HDR, HDR_WAIT, LOAD, SEND, WAIT, DONE
  } state_t;

  state_t                state;
  logic [WORD_WIDTH-1:0] shiftReg;
  logic [WORD_WIDTH-1:0] shiftNext;
  logic [IDX_W-1:0]      byteIdx;

  // The outgoing byte always sits at the end of the shift register that leaves first.
  function automatic logic [7:0] pickByte(input logic [WORD_WIDTH-1:0] w);
    if (MSB_FIRST != 0) return w[WORD_WIDTH-1 -: 8];
    else                return w[7:0];
  endfunction

  assign shiftNext = (MSB_FIRST != 0) ? (shiftReg << 8) : (shiftReg >> 8);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      tx_start     <= 1'b0;
      tx_data      <= 8'h00;
      sent_flag    <= 1'b0;
      word_addr    <= '0;
      send_counter <= '0;
      shiftReg     <= '0;
      byteIdx      <= '0;
    end else begin
      tx_start  <= 1'b0;
      tx_data   <= 8'h00;
      sent_flag <= 1'b0;
      // Abort beats a same-cycle tx_done, so the counter and address freeze where they are.
      if (state != IDLE && abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              send_counter <= '0;
              word_addr    <= '0;
              busy         <= 1'b1;
              if (HEADER_EN != 0) begin
                state    <= HDR;
                tx_start <= 1'b1;
                tx_data  <= HEADER;
              end else begin
                state <= LOAD;
              end
            end
          end
          HDR: state <= HDR_WAIT;
          HDR_WAIT: begin
            if (tx_done) begin
              send_counter <= send_counter + CNT_WIDTH'(1);
              state        <= LOAD;
            end
          end
          LOAD: begin
            shiftReg <= word_in;
            byteIdx  <= '0;
            state    <= SEND;
            tx_start <= 1'b1;
            tx_data  <= pickByte(word_in);
          end
          SEND: state <= WAIT;
          WAIT: begin
            if (tx_done) begin
              send_counter <= send_counter + CNT_WIDTH'(1);
              if (byteIdx != LAST_BYTE) begin
                shiftReg <= shiftNext;
                byteIdx  <= byteIdx + IDX_W'(1);
                state    <= SEND;
                tx_start <= 1'b1;
                tx_data  <= pickByte(shiftNext);
              end else if (word_addr == LAST_WORD) begin
                state     <= DONE;
                sent_flag <= 1'b1;
              end else begin
                word_addr <= word_addr + ADDR_WIDTH'(1);
                state     <= LOAD;
              end
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_debug_dump_tx.sv
// tb/tb_debug_dump_tx.sv - directed self-checking bench for debug_dump_tx
// Three instances: defaults, LSB-first without header, byte-wide words with counter wrap.

module tb_debug_dump_tx;

  logic clk;
  logic reset;

  logic        start0, abort0, txDone0, txStart0, busy0, sent0;
  logic [4:0]  addr0;
  logic [31:0] wordIn0;
  logic [7:0]  txData0, cnt0;

  logic        start1, abort1, txDone1, txStart1, busy1, sent1;
  logic [0:0]  addr1;
  logic [31:0] wordIn1;
  logic [7:0]  txData1, cnt1;

  logic        start2, abort2, txDone2, txStart2, busy2, sent2;
  logic [8:0]  addr2;
  logic [7:0]  wordIn2, txData2, cnt2;

  int checks = 0;
  int errors = 0;

  logic [7:0] log0[$];
  logic [7:0] log1[$];
  logic [7:0] log2[$];
  int addrLog2[$];
  int sentCount0 = 0, sentCount1 = 0, sentCount2 = 0;
  int busyCycles2 = 0, zeroViol = 0;
  int pend0 = 0, pend1 = 0, pend2 = 0;
  bit echo1 = 0, spur1 = 0, idleSpur1 = 0;

  assign wordIn0 = {4{8'({3'b000, addr0} * 8'd17)}};
  assign wordIn1 = (addr1 == 1'b1) ? 32'h01234567 : 32'hDEADBEEF;
  assign wordIn2 = 8'({23'd0, addr2} * 32'd7 + 32'd3);

  debug_dump_tx dut0 (
    .clk(clk), .reset(reset), .start(start0), .abort(abort0),
    .word_addr(addr0), .word_in(wordIn0), .tx_start(txStart0), .tx_data(txData0),
    .tx_done(txDone0), .busy(busy0), .sent_flag(sent0), .send_counter(cnt0)
  );

  debug_dump_tx #(.NUM_WORDS(2), .ADDR_WIDTH(1), .MSB_FIRST(0), .HEADER_EN(0)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .abort(abort1),
    .word_addr(addr1), .word_in(wordIn1), .tx_start(txStart1), .tx_data(txData1),
    .tx_done(txDone1), .busy(busy1), .sent_flag(sent1), .send_counter(cnt1)
  );

  debug_dump_tx #(.WORD_WIDTH(8), .NUM_WORDS(300), .ADDR_WIDTH(9), .CNT_WIDTH(8),
                  .HEADER_EN(0)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .abort(abort2),
    .word_addr(addr2), .word_in(wordIn2), .tx_start(txStart2), .tx_data(txData2),
    .tx_done(txDone2), .busy(busy2), .sent_flag(sent2), .send_counter(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // UART model for dut0: acknowledge three cycles after each tx_start.
  initial begin
    txDone0 = 1'b0;
    forever begin
      @(negedge clk);
      txDone0 = 1'b0;
      if (pend0 > 0) begin
        pend0--;
        if (pend0 == 0) txDone0 = 1'b1;
      end
      if (txStart0 === 1'b1) begin
        log0.push_back(txData0);
        pend0 = 3;
      end
      if (sent0 === 1'b1) sentCount0++;
      if (reset === 1'b0 && txStart0 === 1'b0 && txData0 !== 8'h00) zeroViol++;
    end
  end

  // UART model for dut1: two-cycle ack, optional echo pulse and idle noise.
  initial begin
    txDone1 = 1'b0;
    forever begin
      @(negedge clk);
      txDone1 = idleSpur1;
      if (echo1) begin
        if (spur1) txDone1 = 1'b1;
        echo1 = 1'b0;
      end
      if (pend1 > 0) begin
        pend1--;
        if (pend1 == 0) begin
          txDone1 = 1'b1;
          echo1   = 1'b1;
        end
      end
      if (txStart1 === 1'b1) begin
        log1.push_back(txData1);
        pend1 = 2;
      end
      if (sent1 === 1'b1) sentCount1++;
      if (reset === 1'b0 && txStart1 === 1'b0 && txData1 !== 8'h00) zeroViol++;
    end
  end

  // UART model for dut2: fastest legal ack, one cycle after tx_start.
  initial begin
    txDone2 = 1'b0;
    forever begin
      @(negedge clk);
      txDone2 = 1'b0;
      if (pend2 > 0) begin
        pend2--;
        if (pend2 == 0) txDone2 = 1'b1;
      end
      if (txStart2 === 1'b1) begin
        log2.push_back(txData2);
        addrLog2.push_back(int'(addr2));
        pend2 = 1;
      end
      if (sent2 === 1'b1) sentCount2++;
      if (busy2 === 1'b1) busyCycles2++;
      if (reset === 1'b0 && txStart2 === 1'b0 && txData2 !== 8'h00) zeroViol++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy0, txStart0, sent0} !== 3'b000) begin
      errors++; $display("FAIL reset_flags0 got %b want 000", {busy0, txStart0, sent0});
    end
    checks++;
    if (txData0 !== 8'h00 || addr0 !== 5'd0 || cnt0 !== 8'h00) begin
      errors++; $display("FAIL reset_data0 got data=%h addr=%h cnt=%h want 0", txData0, addr0, cnt0);
    end
    checks++;
    if ({busy1, busy2, txStart1, txStart2, sent1, sent2} !== 6'b0) begin
      errors++; $display("FAIL reset_flags12 got %b want 0", {busy1, busy2, txStart1, txStart2, sent1, sent2});
    end
    checks++;
    if (cnt1 !== 8'h00 || cnt2 !== 8'h00 || addr2 !== 9'd0) begin
      errors++; $display("FAIL reset_cnt12 got cnt1=%h cnt2=%h addr2=%h want 0", cnt1, cnt2, addr2);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_dump();
    int s;
    logic [7:0] expByte;
    log0.delete();
    s = sentCount0;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    checks++;
    if ({busy0, txStart0} !== 2'b11 || txData0 !== 8'hA5) begin
      errors++; $display("FAIL hdr_first got busy=%b start=%b data=%h want 1 1 a5", busy0, txStart0, txData0);
    end
    checks++;
    if (cnt0 !== 8'h00 || addr0 !== 5'd0) begin
      errors++; $display("FAIL start_clear got cnt=%h addr=%h want 0 0", cnt0, addr0);
    end
    for (int n = 0; n < 2000 && busy0 === 1'b1; n++) @(negedge clk);
    checks++;
    if (busy0 !== 1'b0) begin
      errors++; $display("FAIL full_timeout got busy=%b want 0", busy0);
    end
    checks++;
    if (log0.size() != 129) begin
      errors++; $display("FAIL full_len got %0d want 129", log0.size());
    end
    for (int i = 0; i < log0.size() && i < 129; i++) begin
      expByte = (i == 0) ? 8'hA5 : 8'((i - 1) / 4 * 17);
      checks++;
      if (log0[i] !== expByte) begin
        errors++; $display("FAIL full_byte[%0d] got %h want %h", i, log0[i], expByte);
        break;
      end
    end
    checks++;
    if (cnt0 !== 8'h81) begin
      errors++; $display("FAIL full_cnt got %h want 81", cnt0);
    end
    checks++;
    if (sentCount0 - s != 1) begin
      errors++; $display("FAIL full_sent got %0d pulses want 1", sentCount0 - s);
    end
  endtask

  task automatic test_abort();
    int s;
    log0.delete();
    s = sentCount0;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    for (int n = 0; n < 200 && cnt0 !== 8'd5; n++) @(negedge clk);
    checks++;
    if (cnt0 !== 8'd5) begin
      errors++; $display("FAIL abort_reach got cnt=%h want 05", cnt0);
    end
    abort0 = 1'b1;
    @(negedge clk);
    abort0 = 1'b0;
    checks++;
    if (busy0 !== 1'b0 || txStart0 !== 1'b0) begin
      errors++; $display("FAIL abort_idle got busy=%b start=%b want 0 0", busy0, txStart0);
    end
    checks++;
    if (cnt0 !== 8'd5 || addr0 !== 5'd1) begin
      errors++; $display("FAIL abort_freeze got cnt=%h addr=%h want 05 01", cnt0, addr0);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (log0.size() != 5 || sentCount0 != s || cnt0 !== 8'd5) begin
      errors++; $display("FAIL abort_quiet got bytes=%0d sent=%0d cnt=%h want 5 0 05", log0.size(), sentCount0 - s, cnt0);
    end
    log0.delete();
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    checks++;
    if (txStart0 !== 1'b1 || txData0 !== 8'hA5 || cnt0 !== 8'h00 || addr0 !== 5'd0) begin
      errors++; $display("FAIL abort_restart got start=%b data=%h cnt=%h addr=%h want 1 a5 00 00", txStart0, txData0, cnt0, addr0);
    end
    for (int n = 0; n < 2000 && busy0 === 1'b1; n++) @(negedge clk);
    checks++;
    if (busy0 !== 1'b0 || cnt0 !== 8'h81 || log0.size() != 129 || sentCount0 - s != 1) begin
      errors++; $display("FAIL abort_redump got busy=%b cnt=%h bytes=%0d sent=%0d want 0 81 129 1", busy0, cnt0, log0.size(), sentCount0 - s);
    end
    // Abort in the same cycle as the first acknowledge on dut1.
    log1.delete();
    spur1 = 1'b0;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int n = 0; n < 10 && txStart1 !== 1'b1; n++) @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    abort1 = 1'b1;
    checks++;
    if (txDone1 !== 1'b1) begin
      errors++; $display("FAIL abort_done_align got tx_done=%b want 1", txDone1);
    end
    @(negedge clk);
    abort1 = 1'b0;
    checks++;
    if (busy1 !== 1'b0 || cnt1 !== 8'h00) begin
      errors++; $display("FAIL abort_vs_done got busy=%b cnt=%h want 0 00", busy1, cnt1);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_lsb_first_spurious();
    int s;
    logic [7:0] exp1 [8];
    exp1 = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h67, 8'h45, 8'h23, 8'h01};
    log1.delete();
    s = sentCount1;
    spur1 = 1'b1;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    checks++;
    if (busy1 !== 1'b1 || txStart1 !== 1'b0) begin
      errors++; $display("FAIL lsb_load got busy=%b start=%b want 1 0", busy1, txStart1);
    end
    @(negedge clk);
    checks++;
    if (txStart1 !== 1'b1 || txData1 !== 8'hEF) begin
      errors++; $display("FAIL lsb_first got start=%b data=%h want 1 ef", txStart1, txData1);
    end
    repeat (2) @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int n = 0; n < 200 && busy1 === 1'b1; n++) @(negedge clk);
    checks++;
    if (busy1 !== 1'b0 || log1.size() != 8) begin
      errors++; $display("FAIL lsb_len got busy=%b bytes=%0d want 0 8", busy1, log1.size());
    end
    for (int i = 0; i < log1.size() && i < 8; i++) begin
      checks++;
      if (log1[i] !== exp1[i]) begin
        errors++; $display("FAIL lsb_byte[%0d] got %h want %h", i, log1[i], exp1[i]);
        break;
      end
    end
    checks++;
    if (cnt1 !== 8'd8 || sentCount1 - s != 1) begin
      errors++; $display("FAIL lsb_end got cnt=%h sent=%0d want 08 1", cnt1, sentCount1 - s);
    end
    spur1 = 1'b0;
    idleSpur1 = 1'b1;
    repeat (4) @(negedge clk);
    idleSpur1 = 1'b0;
    @(negedge clk);
    checks++;
    if (cnt1 !== 8'd8 || log1.size() != 8 || busy1 !== 1'b0) begin
      errors++; $display("FAIL idle_done_ignored got cnt=%h bytes=%0d busy=%b want 08 8 0", cnt1, log1.size(), busy1);
    end
  endtask

  task automatic test_reset_mid_dump();
    int s;
    logic [7:0] expByte;
    s = sentCount0;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    for (int n = 0; n < 200 && !(cnt0 === 8'd6 && txStart0 === 1'b1); n++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (addr0 !== 5'd1 || busy0 !== 1'b1) begin
      errors++; $display("FAIL rst_setup got addr=%h busy=%b want 01 1", addr0, busy0);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({busy0, txStart0, sent0} !== 3'b000 || txData0 !== 8'h00 || addr0 !== 5'd0 || cnt0 !== 8'h00) begin
      errors++; $display("FAIL rst_mid got flags=%b data=%h addr=%h cnt=%h want 0", {busy0, txStart0, sent0}, txData0, addr0, cnt0);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (sentCount0 != s || busy0 !== 1'b0) begin
      errors++; $display("FAIL rst_no_sent got sent=%0d busy=%b want 0 0", sentCount0 - s, busy0);
    end
    log0.delete();
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    for (int n = 0; n < 2000 && busy0 === 1'b1; n++) @(negedge clk);
    checks++;
    if (busy0 !== 1'b0 || log0.size() != 129 || cnt0 !== 8'h81 || sentCount0 - s != 1) begin
      errors++; $display("FAIL rst_redump got busy=%b bytes=%0d cnt=%h sent=%0d want 0 129 81 1", busy0, log0.size(), cnt0, sentCount0 - s);
    end
    for (int i = 0; i < log0.size() && i < 129; i++) begin
      expByte = (i == 0) ? 8'hA5 : 8'((i - 1) / 4 * 17);
      checks++;
      if (log0[i] !== expByte) begin
        errors++; $display("FAIL rst_byte[%0d] got %h want %h", i, log0[i], expByte);
        break;
      end
    end
  endtask

  task automatic test_wrap();
    int s;
    logic [7:0] expByte;
    log2.delete();
    addrLog2.delete();
    s = sentCount2;
    busyCycles2 = 0;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int n = 0; n < 1500 && busy2 === 1'b1; n++) @(negedge clk);
    checks++;
    if (busy2 !== 1'b0) begin
      errors++; $display("FAIL wrap_timeout got busy=%b want 0", busy2);
    end
    checks++;
    if (busyCycles2 != 901) begin
      errors++; $display("FAIL wrap_min_len got %0d busy cycles want 901", busyCycles2);
    end
    checks++;
    if (log2.size() != 300 || addrLog2.size() != 300) begin
      errors++; $display("FAIL wrap_len got bytes=%0d addrs=%0d want 300", log2.size(), addrLog2.size());
    end
    for (int i = 0; i < log2.size() && i < 300; i++) begin
      expByte = 8'(i * 7 + 3);
      checks++;
      if (log2[i] !== expByte || addrLog2[i] != i) begin
        errors++; $display("FAIL wrap_item[%0d] got byte=%h addr=%0d want %h %0d", i, log2[i], addrLog2[i], expByte, i);
        break;
      end
    end
    checks++;
    if (cnt2 !== 8'd44 || sentCount2 - s != 1) begin
      errors++; $display("FAIL wrap_cnt got cnt=%0d sent=%0d want 44 1", cnt2, sentCount2 - s);
    end
  endtask

  initial begin
    reset  = 1'b1;
    start0 = 1'b0; abort0 = 1'b0;
    start1 = 1'b0; abort1 = 1'b0;
    start2 = 1'b0; abort2 = 1'b0;
    test_reset();
    test_full_dump();
    test_abort();
    test_lsb_first_spurious();
    test_reset_mid_dump();
    test_wrap();
    checks++;
    if (zeroViol != 0) begin
      errors++; $display("FAIL idle_tx_data got %0d nonzero cycles want 0", zeroViol);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
